// File: rtl/peregrine_pif_slave_responder_pkg.sv
// Shared constants and types for the peregrine inbound-PIF slave responder.
// Opcodes, response status codes, bus widths and the responder FSM state.
package peregrine_pif_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 6;
  localparam int PRI_W  = 2;

  localparam logic [3:0] OP_READ  = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h8;
  localparam logic [3:0] OP_BREAD = 4'h1;

  localparam logic [1:0] OK       = 2'b00;
  localparam logic [1:0] ADDR_ERR = 2'b01;
  localparam logic [1:0] UNSUP    = 2'b10;

  typedef enum logic [1:0] {IDLE, RESP, BURST} state_t;

endpackage

// File: rtl/peregrine_pif_slave_responder_if.sv
// PIF request/response signal bundle between an initiator (master) and the
// slave responder (slave).
interface peregrine_pif_slave_responder_if;
  import peregrine_pif_pkg::*;

  logic              PIReqValid;
  logic              POReqRdy;
  logic [7:0]        PIReqCntl;
  logic [ADDR_W-1:0] PIReqAdrs;
  logic [DATA_W-1:0] PIReqData;
  logic [3:0]        PIReqDataBE;
  logic [ID_W-1:0]   PIReqId;
  logic [PRI_W-1:0]  PIReqPriority;
  logic              PORespValid;
  logic              PIRespRdy;
  logic [7:0]        PORespCntl;
  logic [DATA_W-1:0] PORespData;
  logic [ID_W-1:0]   PORespId;
  logic [PRI_W-1:0]  PORespPriority;

  modport master (
    output PIReqValid, PIReqCntl, PIReqAdrs, PIReqData, PIReqDataBE,
           PIReqId, PIReqPriority, PIRespRdy,
    input  POReqRdy, PORespValid, PORespCntl, PORespData, PORespId,
           PORespPriority
  );

  modport slave (
    input  PIReqValid, PIReqCntl, PIReqAdrs, PIReqData, PIReqDataBE,
           PIReqId, PIReqPriority, PIRespRdy,
    output POReqRdy, PORespValid, PORespCntl, PORespData, PORespId,
           PORespPriority
  );

endinterface

// File: rtl/peregrine_pif_slave_responder_ram.sv
// Word-addressed local RAM: byte-enabled synchronous write port and a
// combinational read port. Contents are deliberately not reset.
module peregrine_pif_slave_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_be,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/peregrine_pif_slave_responder.sv
// Inbound-PIF slave endpoint: single read, single write and wrapping block
// read against a local RAM, one request outstanding, error responses otherwise.
module peregrine_pif_slave_responder
  import peregrine_pif_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h6000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter bit          ADDR_CHECK = 1'b1
) (
  input  logic                                  CLK,
  input  logic                                  RESET_N,
  peregrine_pif_slave_responder_if.slave        bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                r_state;
  logic                  r_reqRdy;
  logic                  r_respValid;
  logic [1:0]            r_status;
  logic                  r_last;
  logic [DATA_W-1:0]     r_data;
  logic [ID_W-1:0]       r_id;
  logic [PRI_W-1:0]      r_pri;
  logic [3:0]            r_beat;
  logic [3:0]            r_nMinus1;
  logic [DEPTH_LOG2-1:0] r_start;

  logic [ADDR_W-1:0]     w_off;
  logic [DEPTH_LOG2-1:0] w_word;
  logic                  w_inWin;
  logic [3:0]            w_op;
  logic [3:0]            w_nMinus1;
  logic                  w_burstFits;
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_we;
  logic [3:0]            w_nextBeat;
  logic [DEPTH_LOG2-1:0] w_mask;
  logic [DEPTH_LOG2-1:0] w_burstWord;
  logic [DEPTH_LOG2-1:0] w_rdAddr;
  logic [DATA_W-1:0]     w_rdData;
  logic                  w_unused;

  assign w_off       = bus.PIReqAdrs - BASE_ADDR;
  assign w_word      = w_off[DEPTH_LOG2+1:2];
  assign w_inWin     = !ADDR_CHECK || (w_off[ADDR_W-1:DEPTH_LOG2+2] == '0);
  assign w_op        = bus.PIReqCntl[7:4];
  assign w_nMinus1   = 4'((5'd2 << bus.PIReqCntl[2:1]) - 5'd1);
  assign w_burstFits = ({28'd0, w_nMinus1} < 32'(DEPTH));
  assign w_accept    = bus.PIReqValid & r_reqRdy;
  assign w_xfer      = r_respValid & bus.PIRespRdy;
  assign w_we        = w_accept && (w_op == OP_WRITE) && w_inWin;
  assign w_unused    = &{1'b0, bus.PIReqCntl[3], bus.PIReqCntl[0], w_off[1:0]};

  // Critical-word-first: the beat after the current one, wrapped inside the
  // N-aligned window that contains the start word.
  assign w_nextBeat  = r_beat + 4'd1;
  assign w_mask      = DEPTH_LOG2'(r_nMinus1);
  assign w_burstWord = (r_start & ~w_mask) |
                       ((r_start + DEPTH_LOG2'(w_nextBeat)) & w_mask);
  assign w_rdAddr    = (r_state == BURST) ? w_burstWord : w_word;

  peregrine_pif_slave_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (CLK),
    .i_we    (w_we),
    .i_waddr (w_word),
    .i_wdata (bus.PIReqData),
    .i_be    (bus.PIReqDataBE),
    .i_raddr (w_rdAddr),
    .o_rdata (w_rdData)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_reqRdy    <= 1'b0;
      r_respValid <= 1'b0;
      r_status    <= OK;
      r_last      <= 1'b0;
      r_data      <= '0;
      r_id        <= '0;
      r_pri       <= '0;
      r_beat      <= '0;
      r_nMinus1   <= '0;
      r_start     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_reqRdy <= 1'b1;
          if (w_accept) begin
            r_reqRdy    <= 1'b0;
            r_respValid <= 1'b1;
            r_id        <= bus.PIReqId;
            r_pri       <= bus.PIReqPriority;
            r_last      <= 1'b1;
            r_data      <= '0;
            r_status    <= OK;
            r_state     <= RESP;
            case (w_op)
              OP_READ: begin
                if (w_inWin) r_data <= w_rdData;
                else         r_status <= ADDR_ERR;
              end
              OP_WRITE: begin
                if (!w_inWin) r_status <= ADDR_ERR;
              end
              OP_BREAD: begin
                if (w_inWin && w_burstFits) begin
                  r_data    <= w_rdData;
                  r_last    <= 1'b0;
                  r_beat    <= '0;
                  r_nMinus1 <= w_nMinus1;
                  r_start   <= w_word;
                  r_state   <= BURST;
                end else begin
                  r_status <= ADDR_ERR;
                end
              end
              default: r_status <= UNSUP;
            endcase
          end
        end
        RESP: begin
          if (w_xfer) begin
            r_respValid <= 1'b0;
            r_reqRdy    <= 1'b1;
            r_state     <= IDLE;
          end
        end
        BURST: begin
          if (w_xfer) begin
            if (r_last) begin
              r_respValid <= 1'b0;
              r_reqRdy    <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_beat <= w_nextBeat;
              r_data <= w_rdData;
              r_last <= (w_nextBeat == r_nMinus1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.POReqRdy       = r_reqRdy;
  assign bus.PORespValid    = r_respValid;
  assign bus.PORespCntl     = {5'b00000, r_status, r_last};
  assign bus.PORespData     = r_data;
  assign bus.PORespId       = r_id;
  assign bus.PORespPriority = r_pri;

endmodule

// File: tb/tb_peregrine_pif_slave_responder.sv
// Self-checking bench for the PIF slave responder: table of single
// transactions, then stalled block read and mid-burst reset sequences.
module tb_peregrine_pif_slave_responder;
  import peregrine_pif_pkg::*;

  localparam logic [31:0] BASE = 32'h6000_0000;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [5:0]  id;
    logic [1:0]  pri;
    logic [1:0]  expStatus;
    logic [31:0] expData;
    bit          chkData;
  } vec_t;

  typedef struct {
    logic [1:0]  status;
    logic        last;
    logic [31:0] data;
    bit          chkData;
    logic [5:0]  id;
    logic [1:0]  pri;
  } exp_t;

  logic CLK;
  logic RESET_N;
  int   checks;
  int   errors;
  exp_t sb[$];
  vec_t tbl[14];

  peregrine_pif_slave_responder_if bus();

  peregrine_pif_slave_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_LOG2 (10),
    .ADDR_CHECK (1'b1)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input logic [1:0] status, input logic last,
                         input logic [31:0] data, input bit chk,
                         input logic [5:0] id, input logic [1:0] pri);
    exp_t e;
    e.status = status; e.last = last; e.data = data;
    e.chkData = chk; e.id = id; e.pri = pri;
    sb.push_back(e);
  endtask

  // Compares every presented beat (stalled or not) to the scoreboard head;
  // the head is retired only when the beat is actually taken.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET_N && bus.PORespValid) begin
        if (sb.size() == 0) begin
          checkOutput("beat_expected", 32'(sb.size()), 32'd1);
        end else begin
          e = sb[0];
          checkOutput("resp_status", 32'(bus.PORespCntl[2:1]), 32'(e.status));
          checkOutput("resp_last", 32'(bus.PORespCntl[0]), 32'(e.last));
          checkOutput("resp_cntl_hi", 32'(bus.PORespCntl[7:3]), 32'd0);
          if (e.chkData) checkOutput("resp_data", bus.PORespData, e.data);
          checkOutput("resp_id", 32'(bus.PORespId), 32'(e.id));
          checkOutput("resp_pri", 32'(bus.PORespPriority), 32'(e.pri));
          if (bus.PIRespRdy) void'(sb.pop_front());
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be, input logic [5:0] id,
                               input logic [1:0] pri);
    int n;
    n = 0;
    @(posedge CLK); #2;
    while (!bus.POReqRdy && n < 50) begin
      @(posedge CLK); #2;
      n++;
    end
    if (!bus.POReqRdy) begin
      checkOutput("req_ready_timeout", 32'(bus.POReqRdy), 32'd1);
      return;
    end
    bus.PIReqValid    = 1'b1;
    bus.PIReqCntl     = {op, 1'b0, size, 1'b1};
    bus.PIReqAdrs     = addr;
    bus.PIReqData     = data;
    bus.PIReqDataBE   = be;
    bus.PIReqId       = id;
    bus.PIReqPriority = pri;
    @(posedge CLK); #1;
    bus.PIReqValid = 1'b0;
    checkOutput("ready_drop", 32'(bus.POReqRdy), 32'd0);
    checkOutput("resp_latency", 32'(bus.PORespValid), 32'd1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (!bus.POReqRdy && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("return_idle", 32'(bus.POReqRdy), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET_N           = 1'b0;
    bus.PIReqValid    = 1'b0;
    bus.PIReqCntl     = '0;
    bus.PIReqAdrs     = '0;
    bus.PIReqData     = '0;
    bus.PIReqDataBE   = '0;
    bus.PIReqId       = '0;
    bus.PIReqPriority = '0;
    bus.PIRespRdy     = 1'b1;

    fork
      monitor();
      begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    //               op        sz  addr            data          be     id     pri   status    expData       chk
    tbl[0]  = '{OP_WRITE, 2'd0, BASE+32'h10,   32'hDEADBEEF, 4'hF, 6'd1,  2'd0, OK,       32'h0,        1'b1};
    tbl[1]  = '{OP_READ,  2'd0, BASE+32'h10,   32'h0,        4'hF, 6'd2,  2'd1, OK,       32'hDEADBEEF, 1'b1};
    tbl[2]  = '{OP_WRITE, 2'd0, BASE+32'h20,   32'h11223344, 4'hF, 6'd3,  2'd0, OK,       32'h0,        1'b1};
    tbl[3]  = '{OP_WRITE, 2'd0, BASE+32'h20,   32'h000000AA, 4'h1, 6'd4,  2'd2, OK,       32'h0,        1'b1};
    tbl[4]  = '{OP_READ,  2'd0, BASE+32'h21,   32'h0,        4'hF, 6'd5,  2'd3, OK,       32'h112233AA, 1'b1};
    tbl[5]  = '{OP_READ,  2'd0, BASE-32'h4,    32'h0,        4'hF, 6'd6,  2'd0, ADDR_ERR, 32'h0,        1'b0};
    tbl[6]  = '{4'h5,     2'd0, BASE+32'h10,   32'h0,        4'hF, 6'd7,  2'd1, UNSUP,    32'h0,        1'b0};
    tbl[7]  = '{OP_READ,  2'd0, BASE+32'h10,   32'h0,        4'hF, 6'd8,  2'd0, OK,       32'hDEADBEEF, 1'b1};
    tbl[8]  = '{OP_WRITE, 2'd0, BASE+32'h10,   32'h0,        4'h0, 6'd9,  2'd0, OK,       32'h0,        1'b1};
    tbl[9]  = '{OP_READ,  2'd0, BASE+32'h10,   32'h0,        4'hF, 6'd10, 2'd2, OK,       32'hDEADBEEF, 1'b1};
    tbl[10] = '{OP_READ,  2'd0, BASE+32'h1000, 32'h0,        4'hF, 6'd11, 2'd0, ADDR_ERR, 32'h0,        1'b0};
    tbl[11] = '{OP_WRITE, 2'd0, BASE+32'h1000, 32'h5555,     4'hF, 6'd12, 2'd1, ADDR_ERR, 32'h0,        1'b0};
    tbl[12] = '{OP_BREAD, 2'd0, BASE-32'h40,   32'h0,        4'hF, 6'd13, 2'd0, ADDR_ERR, 32'h0,        1'b0};
    tbl[13] = '{4'hF,     2'd0, BASE,          32'h0,        4'hF, 6'd63, 2'd3, UNSUP,    32'h0,        1'b0};

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_req_rdy", 32'(bus.POReqRdy), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.PORespValid), 32'd0);
    checkOutput("rst_resp_cntl", 32'(bus.PORespCntl), 32'd0);
    checkOutput("rst_resp_data", bus.PORespData, 32'd0);
    checkOutput("rst_resp_id", 32'(bus.PORespId), 32'd0);
    checkOutput("rst_resp_pri", 32'(bus.PORespPriority), 32'd0);
    #1;
    RESET_N = 1'b1;
    #1;
    checkOutput("rdy_before_edge", 32'(bus.POReqRdy), 32'd0);
    @(posedge CLK); #1;
    checkOutput("rdy_after_reset", 32'(bus.POReqRdy), 32'd1);

    for (int i = 0; i < 14; i++) begin
      pushExp(tbl[i].expStatus, 1'b1, tbl[i].expData, tbl[i].chkData,
              tbl[i].id, tbl[i].pri);
      applyStimulus(tbl[i].op, tbl[i].size, tbl[i].addr, tbl[i].data,
                    tbl[i].be, tbl[i].id, tbl[i].pri);
      @(posedge CLK); #1;
      checkOutput("min_period_rdy", 32'(bus.POReqRdy), 32'd1);
    end

    $display("[TB] block read with response backpressure");
    for (int k = 4; k < 8; k++) begin
      pushExp(OK, 1'b1, 32'h0, 1'b1, 6'(k), 2'd0);
      applyStimulus(OP_WRITE, 2'd0, BASE + 32'(k * 4), 32'(k), 4'hF, 6'(k), 2'd0);
    end
    waitIdle();
    pushExp(OK, 1'b0, 32'd6, 1'b1, 6'd33, 2'd2);
    pushExp(OK, 1'b0, 32'd7, 1'b1, 6'd33, 2'd2);
    pushExp(OK, 1'b0, 32'd4, 1'b1, 6'd33, 2'd2);
    pushExp(OK, 1'b1, 32'd5, 1'b1, 6'd33, 2'd2);
    bus.PIRespRdy = 1'b1;
    applyStimulus(OP_BREAD, 2'd1, BASE + 32'h18, 32'h0, 4'hF, 6'd33, 2'd2);
    for (int i = 1; i < 8; i++) begin
      @(posedge CLK); #2;
      bus.PIRespRdy = (i % 2 == 0);
    end
    bus.PIRespRdy = 1'b1;
    waitIdle();
    checkOutput("sb_drained_burst", 32'(sb.size()), 32'd0);

    $display("[TB] reset during a 16-beat burst");
    pushExp(OK, 1'b0, 32'd4, 1'b1, 6'd40, 2'd1);
    pushExp(OK, 1'b0, 32'd5, 1'b1, 6'd40, 2'd1);
    applyStimulus(OP_BREAD, 2'd3, BASE + 32'h10, 32'h0, 4'hF, 6'd40, 2'd1);
    @(posedge CLK);
    @(posedge CLK); #2;
    checkOutput("burst_valid_beat2", 32'(bus.PORespValid), 32'd1);
    checkOutput("beats_taken_before_rst", 32'(sb.size()), 32'd0);
    RESET_N = 1'b0;
    #1;
    checkOutput("midrst_resp_valid", 32'(bus.PORespValid), 32'd0);
    checkOutput("midrst_req_rdy", 32'(bus.POReqRdy), 32'd0);
    checkOutput("midrst_resp_cntl", 32'(bus.PORespCntl), 32'd0);
    checkOutput("midrst_resp_data", bus.PORespData, 32'd0);
    sb.delete();
    @(posedge CLK); #2;
    RESET_N = 1'b1;
    #1;
    checkOutput("rdy_before_release_edge", 32'(bus.POReqRdy), 32'd0);
    @(posedge CLK); #1;
    checkOutput("rdy_after_release", 32'(bus.POReqRdy), 32'd1);
    checkOutput("no_resumed_burst", 32'(bus.PORespValid), 32'd0);
    pushExp(OK, 1'b1, 32'h112233AA, 1'b1, 6'd41, 2'd3);
    applyStimulus(OP_READ, 2'd0, BASE + 32'h20, 32'h0, 4'hF, 6'd41, 2'd3);
    waitIdle();
    checkOutput("sb_drained_final", 32'(sb.size()), 32'd0);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
